spi_rx: RTL and testbench

Serial-to-parallel receiver for the SPI link: the peripheral-side consumer of the waveform that the SPI transmitter stage drives (data, data clock, active-low select).
- Synchronises the three async SPI lines into clk_in.
- Samples data on each rising edge of data clock, MSB first.
- Presents each completed word with a one-cycle valid pulse.
- Flags frames aborted mid-word.

---
 rtl/spi_rx.sv | 150 +++++++++++++++
 tb/tb_spi_rx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx.sv
// SPI receiver: synchronises data/clock/select into clk_in and assembles serial bits into words.
// Build option SPI_RX_LSB_FIRST_EN: when defined, the first received bit lands in data_out[0].
module spi_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  data_in,
    input  logic                  data_clk_in,
    input  logic                  sel_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  new_data_out,
    output logic                  busy_out,
    output logic                  error_out
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] sel_sync_q, sel_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  word_q, word_d;
    logic                   word_vld_q, word_vld_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   new_data_q, new_data_d;
    logic                   busy_q, busy_d;
    logic                   error_q, error_d;

    logic                   data_s;
    logic                   clk_s;
    logic                   sel_s;
    logic                   rise;
    logic [DATA_WIDTH-1:0]  shift_next;

    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign sel_s  = sel_sync_q[SYNC_STAGES-1];
    assign rise   = clk_s & ~clk_prev_q;

`ifdef SPI_RX_LSB_FIRST_EN
    assign shift_next = {data_s, shift_q[DATA_WIDTH-1:1]};
`else
    assign shift_next = {shift_q[DATA_WIDTH-2:0], data_s};
`endif

    always_comb begin
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], data_in};
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], data_clk_in};
        sel_sync_d  = {sel_sync_q[SYNC_STAGES-2:0], sel_in};
        clk_prev_d  = clk_s;

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        word_d     = word_q;
        word_vld_d = 1'b0;
        data_d     = data_q;
        new_data_d = 1'b0;
        error_d    = 1'b0;

        // A completed word is published one cycle after its final bit is shifted in.
        if (word_vld_q) begin
            data_d     = word_q;
            new_data_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!sel_s) begin
                    state_d   = RECV;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            RECV: begin
                // Select release takes priority over a coincident clock edge.
                if (sel_s) begin
                    state_d   = IDLE;
                    error_d   = (bit_cnt_q != '0);
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end else if (rise) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        word_d     = shift_next;
                        word_vld_d = 1'b1;
                        bit_cnt_d  = '0;
                        shift_d    = '0;
                    end else begin
                        shift_d   = shift_next;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RECV);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            data_sync_q <= '0;
            clk_sync_q  <= '0;
            sel_sync_q  <= '1;
            clk_prev_q  <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            word_q      <= '0;
            word_vld_q  <= 1'b0;
            data_q      <= '0;
            new_data_q  <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            data_sync_q <= data_sync_d;
            clk_sync_q  <= clk_sync_d;
            sel_sync_q  <= sel_sync_d;
            clk_prev_q  <= clk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            word_q      <= word_d;
            word_vld_q  <= word_vld_d;
            data_q      <= data_d;
            new_data_q  <= new_data_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

    assign data_out     = data_q;
    assign new_data_out = new_data_q;
    assign busy_out     = busy_q;
    assign error_out    = error_q;

endmodule

// File: tb/tb_spi_rx.sv
// Directed bench for spi_rx: drives the SPI transmitter waveform and checks words, pulses and aborts.
module tb_spi_rx;

    logic       clk_in;
    logic       rst_in;
    logic       data_in;
    logic       data_clk_in;
    logic       sel_in;
    logic [7:0] data_out;
    logic       new_data_out;
    logic       busy_out;
    logic       error_out;

    int tests_run;
    int tests_failed;

    logic [7:0] obs_q[$];
    int         nd_cnt;
    int         err_cnt;
    int         both_cnt;

    spi_rx #(
        .DATA_WIDTH (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .data_in     (data_in),
        .data_clk_in (data_clk_in),
        .sel_in      (sel_in),
        .data_out    (data_out),
        .new_data_out(new_data_out),
        .busy_out    (busy_out),
        .error_out   (error_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Outputs are observed on the falling edge, away from the active edge.
    initial begin
        nd_cnt   = 0;
        err_cnt  = 0;
        both_cnt = 0;
    end
    always @(negedge clk_in) begin
        if (new_data_out === 1'b1) begin
            obs_q.push_back(data_out);
            nd_cnt = nd_cnt + 1;
        end
        if (error_out === 1'b1) err_cnt = err_cnt + 1;
        if (new_data_out === 1'b1 && error_out === 1'b1) both_cnt = both_cnt + 1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // One SPI bit: data set while the clock is low, sampled at the rising edge (100-cycle period).
    task automatic send_bits(input logic [7:0] w, input int n);
        logic [7:0] v;
        v = w;
        for (int i = 0; i < n; i++) begin
            data_in = v[7-i];
            wait_cyc(50);
            data_clk_in = 1'b1;
            wait_cyc(50);
            data_clk_in = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_in = 1'b1;
        wait_cyc(3);
        tests_run++;
        if (data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_data_out: got %h want 00", data_out);
        end
        tests_run++;
        if (new_data_out !== 1'b0 || error_out !== 1'b0 || busy_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got nd=%b err=%b busy=%b want 0 0 0",
                     new_data_out, error_out, busy_out);
        end
        rst_in = 1'b0;
        wait_cyc(5);
        tests_run++;
        if (busy_out !== 1'b0 || nd_cnt != 0) begin
            tests_failed++;
            $display("FAIL reset_release: got busy=%b pulses=%0d want 0 0", busy_out, nd_cnt);
        end
    endtask

    task automatic test_single_word;
        int nd0, err0, idx;
        nd0 = nd_cnt; err0 = err_cnt; idx = obs_q.size();
        sel_in = 1'b0;
        wait_cyc(10);
        tests_run++;
        if (busy_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_busy: got %b want 1", busy_out);
        end
        send_bits(8'hA5, 8);
        wait_cyc(20);
        sel_in = 1'b1;
        wait_cyc(20);
        tests_run++;
        if (nd_cnt - nd0 != 1) begin
            tests_failed++;
            $display("FAIL single_pulses: got %0d want 1", nd_cnt - nd0);
        end else begin
            tests_run++;
            if (obs_q[idx] !== 8'hA5) begin
                tests_failed++;
                $display("FAIL single_word: got %h want a5", obs_q[idx]);
            end
        end
        tests_run++;
        if (data_out !== 8'hA5 || err_cnt != err0 || busy_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_after: got data=%h err=%0d busy=%b want a5 0 0",
                     data_out, err_cnt - err0, busy_out);
        end
    endtask

    task automatic test_back_to_back;
        int nd0, err0, idx;
        nd0 = nd_cnt; err0 = err_cnt; idx = obs_q.size();
        sel_in = 1'b0;
        wait_cyc(10);
        send_bits(8'h3C, 8);
        send_bits(8'hFF, 8);
        wait_cyc(20);
        sel_in = 1'b1;
        wait_cyc(20);
        tests_run++;
        if (nd_cnt - nd0 != 2) begin
            tests_failed++;
            $display("FAIL b2b_pulses: got %0d want 2", nd_cnt - nd0);
        end else begin
            tests_run++;
            if (obs_q[idx] !== 8'h3C || obs_q[idx+1] !== 8'hFF) begin
                tests_failed++;
                $display("FAIL b2b_words: got %h %h want 3c ff", obs_q[idx], obs_q[idx+1]);
            end
        end
        tests_run++;
        if (data_out !== 8'hFF || err_cnt != err0) begin
            tests_failed++;
            $display("FAIL b2b_after: got data=%h err=%0d want ff 0", data_out, err_cnt - err0);
        end
    endtask

    task automatic test_short_frame;
        int nd0, err0;
        nd0 = nd_cnt; err0 = err_cnt;
        sel_in = 1'b0;
        wait_cyc(10);
        send_bits(8'h5F, 5);
        wait_cyc(20);
        sel_in = 1'b1;
        wait_cyc(20);
        tests_run++;
        if (err_cnt - err0 != 1) begin
            tests_failed++;
            $display("FAIL short_error: got %0d error cycles want 1", err_cnt - err0);
        end
        tests_run++;
        if (nd_cnt != nd0 || data_out !== 8'hFF) begin
            tests_failed++;
            $display("FAIL short_data: got pulses=%0d data=%h want 0 ff", nd_cnt - nd0, data_out);
        end
    endtask

    task automatic test_reset_mid_frame;
        int nd0, err0, idx;
        err0 = err_cnt;
        sel_in = 1'b0;
        wait_cyc(10);
        send_bits(8'hE0, 3);
        rst_in = 1'b1;
        wait_cyc(2);
        tests_run++;
        if (data_out !== 8'h00 || new_data_out !== 1'b0 || busy_out !== 1'b0 || error_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got data=%h nd=%b busy=%b err=%b want 00 0 0 0",
                     data_out, new_data_out, busy_out, error_out);
        end
        sel_in = 1'b1;
        wait_cyc(5);
        rst_in = 1'b0;
        wait_cyc(10);
        tests_run++;
        if (err_cnt != err0 || data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL midreset_after: got err=%0d data=%h want 0 00", err_cnt - err0, data_out);
        end
        nd0 = nd_cnt; idx = obs_q.size();
        sel_in = 1'b0;
        wait_cyc(10);
        send_bits(8'h81, 8);
        wait_cyc(20);
        sel_in = 1'b1;
        wait_cyc(20);
        tests_run++;
        if (nd_cnt - nd0 != 1 || data_out !== 8'h81 || err_cnt != err0) begin
            tests_failed++;
            $display("FAIL midreset_word: got pulses=%0d data=%h err=%0d want 1 81 0",
                     nd_cnt - nd0, data_out, err_cnt - err0);
        end
    endtask

    task automatic test_noise;
        int nd0, err0;
        nd0 = nd_cnt; err0 = err_cnt;
        for (int i = 0; i < 4; i++) begin
            data_clk_in = 1'b1;
            wait_cyc(10);
            data_clk_in = 1'b0;
            wait_cyc(10);
        end
        tests_run++;
        if (nd_cnt != nd0 || err_cnt != err0 || busy_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL noise_idle: got pulses=%0d err=%0d busy=%b want 0 0 0",
                     nd_cnt - nd0, err_cnt - err0, busy_out);
        end
        // Frame opens with the data clock already high; its fall must not count as a bit.
        data_in = 1'b1;
        data_clk_in = 1'b1;
        wait_cyc(10);
        sel_in = 1'b0;
        wait_cyc(50);
        data_clk_in = 1'b0;
        wait_cyc(20);
        send_bits(8'h5A, 8);
        wait_cyc(20);
        sel_in = 1'b1;
        wait_cyc(20);
        tests_run++;
        if (nd_cnt - nd0 != 1 || data_out !== 8'h5A || err_cnt != err0) begin
            tests_failed++;
            $display("FAIL noise_word: got pulses=%0d data=%h err=%0d want 1 5a 0",
                     nd_cnt - nd0, data_out, err_cnt - err0);
        end
    endtask

    task automatic test_bit_order;
        logic [7:0] exp_word;
`ifdef SPI_RX_LSB_FIRST_EN
        exp_word = 8'h01;
`else
        exp_word = 8'h80;
`endif
        sel_in = 1'b0;
        wait_cyc(10);
        send_bits(8'h80, 8);
        wait_cyc(20);
        sel_in = 1'b1;
        wait_cyc(20);
        tests_run++;
        if (data_out !== exp_word) begin
            tests_failed++;
            $display("FAIL bit_order: got %h want %h", data_out, exp_word);
        end
    endtask

    task automatic test_exclusive;
        tests_run++;
        if (both_cnt != 0) begin
            tests_failed++;
            $display("FAIL exclusive_pulses: got %0d overlapping cycles want 0", both_cnt);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_in       = 1'b1;
        data_in      = 1'b0;
        data_clk_in  = 1'b0;
        sel_in       = 1'b1;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_short_frame();
        test_reset_mid_frame();
        test_noise();
        test_bit_order();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
